// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first.
// One full-subtractor cell is reused for every bit; the borrow between bits is held in
// a flop. A WIDTH-bit subtract takes WIDTH+1 cycles from accepted start to done.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  request; sampled only in idle or done
//   a      minuend, captured on accepted start
//   b      subtrahend, captured on accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse; diff/borrow valid from this cycle
//   diff   a - b mod 2^WIDTH, held until next completion
//   borrow final borrow-out; 1 iff a < b (unsigned)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic             bin_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic accept, last_bit, d_bit, bout;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ bin_q;
    bout     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bin_q);
    last_bit = (cnt_q == CntW'(WIDTH - 1));
    accept   = start && ((state_q == StIdle) || (state_q == StDone));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State plus registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StShift);
      done_q  <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sh_q <= a;
      b_sh_q <= b;
      res_q  <= '0;
      bin_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == StShift) begin
      a_sh_q <= a_sh_q >> 1;
      b_sh_q <= b_sh_q >> 1;
      // Result fills from the MSB side so the first (LSB) bit lands at bit 0 after WIDTH shifts.
      res_q  <= {d_bit, res_q[WIDTH-1:1]};
      bin_q  <= bout;
      cnt_q  <= cnt_q + CntW'(1);
      if (last_bit) begin
        diff_q   <= {d_bit, res_q[WIDTH-1:1]};
        borrow_q <= bout;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed self-checking bench for serial_subtractor
// (WIDTH=8). Expected results come from plain unsigned arithmetic on the operands.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, borrow;
  logic [7:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run one operation from idle. lat counts edges from the accepting edge to the first
  // cycle where done is seen; busy_n counts busy samples before that; done_n counts done
  // samples in that cycle and the following one.
  task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, output int lat,
                       output int busy_n, output int done_n, output logic [7:0] d,
                       output logic br);
    a = ai;
    b = bi;
    start = 1'b1;
    cyc();
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      cyc();
      lat++;
    end
    d = diff;
    br = borrow;
    done_n = done ? 1 : 0;
    cyc();
    if (done) done_n++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({busy, done, diff, borrow} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h borrow=%b want all 0",
               busy, done, diff, borrow);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bn, dn;
    logic [7:0] d;
    logic br;
    do_op(8'h5A, 8'h3C, lat, bn, dn, d, br);
    checks++;
    if (d !== 8'h1E || br !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got %h/%b want 1e/0", d, br);
    end
    checks++;
    if (bn != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 8", bn);
    end
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL basic_latency got %0d want 9", lat);
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL basic_done_width got %0d want 1", dn);
    end
    checks++;
    if (diff !== 8'h1E) begin
      errors++;
      $display("FAIL basic_hold_idle got %h want 1e", diff);
    end
  endtask

  task automatic test_edges();
    int lat, bn, dn;
    logic [7:0] d;
    logic br;
    do_op(8'h00, 8'h01, lat, bn, dn, d, br);
    checks++;
    if (d !== 8'hFF || br !== 1'b1 || lat != 9) begin
      errors++;
      $display("FAIL underflow got %h/%b lat %0d want ff/1 lat 9", d, br, lat);
    end
    do_op(8'h80, 8'h80, lat, bn, dn, d, br);
    checks++;
    if (d !== 8'h00 || br !== 1'b0 || lat != 9) begin
      errors++;
      $display("FAIL equal got %h/%b lat %0d want 00/0 lat 9", d, br, lat);
    end
  endtask

  task automatic test_start_in_shift();
    int lat;
    int pulses;
    a = 8'hC3;
    b = 8'h5A;
    start = 1'b1;
    cyc();
    // Keep start high with fresh operands through the shift phase.
    for (int i = 0; i < 7; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      cyc();
    end
    start = 1'b0;
    lat = 8;
    while (!done && lat < 30) begin
      cyc();
      lat++;
    end
    checks++;
    if (diff !== 8'h69 || borrow !== 1'b0 || lat != 9) begin
      errors++;
      $display("FAIL start_in_shift got %h/%b lat %0d want 69/0 lat 9", diff, borrow, lat);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL start_in_shift_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int lat, held_bad;
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    cyc();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      cyc();
      lat++;
    end
    checks++;
    if (diff !== 8'h22 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got %h/%b want 22/0", diff, borrow);
    end
    // Request the next operation in the done cycle.
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done);
    end
    lat = 1;
    held_bad = 0;
    while (!done && lat < 30) begin
      if (diff !== 8'h22 || borrow !== 1'b0) held_bad++;
      cyc();
      lat++;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL b2b_prior_held got %0d bad cycles want 0", held_bad);
    end
    checks++;
    if (diff !== 8'hF0 || borrow !== 1'b1 || lat != 9) begin
      errors++;
      $display("FAIL b2b_second got %h/%b lat %0d want f0/1 lat 9", diff, borrow, lat);
    end
    cyc();
  endtask

  task automatic test_reset_mid_shift();
    int pulses, lat, bn, dn;
    logic [7:0] d;
    logic br;
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, borrow} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid_shift got busy=%b done=%b diff=%h borrow=%b want all 0",
               busy, done, diff, borrow);
    end
    cyc();
    cyc();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_abort got %0d active cycles want 0", pulses);
    end
    do_op(8'h07, 8'h09, lat, bn, dn, d, br);
    checks++;
    if (d !== 8'hFE || br !== 1'b1 || lat != 9) begin
      errors++;
      $display("FAIL after_reset got %h/%b lat %0d want fe/1 lat 9", d, br, lat);
    end
  endtask

  task automatic test_random();
    int lat, bn, dn;
    logic [7:0] d, ai, bi, exp_d;
    logic br, exp_b;
    for (int n = 0; n < 1000; n++) begin
      ai = 8'($urandom);
      bi = 8'($urandom);
      exp_d = 8'((int'(ai) - int'(bi) + 256) % 256);
      exp_b = (ai < bi);
      do_op(ai, bi, lat, bn, dn, d, br);
      checks++;
      if (d !== exp_d) begin
        errors++;
        $display("FAIL rand_diff a=%h b=%h got %h want %h", ai, bi, d, exp_d);
      end
      checks++;
      if (br !== exp_b) begin
        errors++;
        $display("FAIL rand_borrow a=%h b=%h got %b want %b", ai, bi, br, exp_b);
      end
      checks++;
      if (lat != 9 || dn != 1) begin
        errors++;
        $display("FAIL rand_timing a=%h b=%h got lat %0d done %0d want 9 1", ai, bi, lat, dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_start_in_shift();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
